// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite slave types: transfer/size encodings,
// response codes, slave FSM states and byte-lane helper.
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } slv_state_e;

    // Little-endian lane mask for a transfer of 2**size bytes.
    function automatic logic [7:0] byte_en(
        input logic [2:0] size,
        input logic [2:0] lo
    );
        logic [7:0] m;
        m = 8'hFF;
        unique case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lo;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the
// SRAM slave; HREADY is the bus-wide ready.
interface ahb_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE,
        output HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE,
        input  HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_bank.sv
// SRAM array: byte-enable write port and a
// combinational read port sharing one word index.
module ahb_sram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Commit only the enabled byte lanes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with sizing, wait states and
// two-cycle ERROR. AHB_SLV_RO_REGION_EN: top quarter read-only.
module ahb_sram_slave
    import ahb_slv_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_sram_slave_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYTES = DEPTH * NB;

    slv_state_e        state_q;
    slv_state_e        state_d;
    slv_state_e        start_st;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  lo_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic              err_q;
    logic [3:0]        cnt_q;

    logic              req_valid;
    logic              take;
    logic              req_err;
    logic              misalign;
    logic              too_big;
    logic              oor;
    logic [2:0]        amask;
    logic              we;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] rdata;

    assign req_valid = (bus.HTRANS == HT_NONSEQ)
                     | (bus.HTRANS == HT_SEQ);

    // No new address phase is taken while we stall.
    assign take = bus.HSEL & bus.HREADY & req_valid
                & (state_q != WAIT) & (state_q != ERR1);

    // Classify the address phase as legal or ERROR.
    always_comb begin
        amask = 3'b111;
        unique case (bus.HSIZE)
            SZ_BYTE: amask = 3'b000;
            SZ_HALF: amask = 3'b001;
            SZ_WORD: amask = 3'b011;
            default: amask = 3'b111;
        endcase
        misalign = |(bus.HADDR[2:0] & amask);
        too_big  = (32'd8 << bus.HSIZE) > 32'(DATA_W);
        oor      = bus.HADDR >= ADDR_W'(BYTES);
        req_err  = misalign | too_big | oor;
`ifdef AHB_SLV_RO_REGION_EN
        if (bus.HWRITE &&
            bus.HADDR[OFF_W +: IDX_W] >= IDX_W'(3 * DEPTH / 4)) begin
            req_err = 1'b1;
        end
`endif
    end

    assign start_st = req_err ? ERR1
                    : ((WAIT_STATES > 0) ? WAIT : DATA);

    // State register and captured address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                idx_q   <= bus.HADDR[OFF_W +: IDX_W];
                lo_q    <= bus.HADDR[OFF_W-1:0];
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE;
                err_q   <= req_err;
                cnt_q   <= 4'(WAIT_STATES);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Next state and per-state bus response.
    always_comb begin
        state_d       = state_q;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = RESP_OKAY;
        unique case (state_q)
            IDLE, DATA: begin
                state_d = take ? start_st : IDLE;
            end
            WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (cnt_q <= 4'd1) state_d = DATA;
            end
            ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = RESP_ERROR;
                state_d       = ERR2;
            end
            ERR2: begin
                bus.HRESP = RESP_ERROR;
                state_d   = take ? start_st : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign we = (state_q == DATA) & write_q & ~err_q;
    assign be = NB'(byte_en(size_q, 3'(lo_q)));

    assign bus.HRDATA = (state_q == DATA && !write_q)
                      ? rdata : '0;

    ahb_sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .we    (we),
        .be    (be),
        .addr  (idx_q),
        .wdata (bus.HWDATA),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: dut0 has zero wait states,
// dut1 has three; both share address/data drivers.
module tb_ahb_sram_slave;
    import ahb_slv_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel   = 2'b00;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize  = 3'd2;
    logic [31:0] hwdata = '0;
    logic [31:0] nxt_wd = '0;

    always #5 clk = ~clk;

    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

    assign if0.HSEL   = sel[0];
    assign if0.HADDR  = haddr;
    assign if0.HTRANS = htrans;
    assign if0.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;
    assign if0.HWDATA = hwdata;
    assign if0.HREADY = if0.HREADYOUT;

    assign if1.HSEL   = sel[1];
    assign if1.HADDR  = haddr;
    assign if1.HTRANS = htrans;
    assign if1.HWRITE = hwrite;
    assign if1.HSIZE  = hsize;
    assign if1.HWDATA = hwdata;
    assign if1.HREADY = if1.HREADYOUT;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if0.slave)
    );

    ahb_sram_slave #(.WAIT_STATES(3)) dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if1.slave)
    );

    typedef struct {
        bit          rd;
        bit          neq;
        logic [31:0] data;
        bit          resp;
        int          waits;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend[2];
    int   wc[2];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h",
                     nm, act, req);
        end
    endtask

    // Monitor step for one DUT, evaluated at negedge.
    task automatic mon(input int d,
                       input logic rdy,
                       input logic rsp,
                       input logic [31:0] rdat,
                       input logic acc);
        exp_t e;
        if (!rst_n) begin
            pend[d] = 1'b0;
            wc[d]   = 0;
            return;
        end
        if (pend[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer dut%0d", d);
                pend[d] = 1'b0;
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                if (!rdy) begin
                    wc[d]++;
                    chk($sformatf("stall_resp dut%0d", d),
                        32'(rsp), 32'(e.resp));
                end else begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    chk($sformatf("resp dut%0d", d),
                        32'(rsp), 32'(e.resp));
                    chk($sformatf("waits dut%0d", d),
                        32'(wc[d]), 32'(e.waits));
                    if (e.rd && e.neq) begin
                        checks++;
                        if (rdat === e.data) begin
                            errors++;
                            $display("FAIL rdata_ne dut%0d actual %h required not %h",
                                     d, rdat, e.data);
                        end
                    end else if (e.rd) begin
                        chk($sformatf("rdata dut%0d", d),
                            rdat, e.data);
                    end
                    pend[d] = 1'b0;
                    wc[d]   = 0;
                end
            end
        end
        if (acc) pend[d] = 1'b1;
    endtask

    always @(negedge clk) begin
        mon(0, if0.HREADYOUT, if0.HRESP, if0.HRDATA,
            if0.HSEL & if0.HREADY & if0.HTRANS[1]);
        mon(1, if1.HREADYOUT, if1.HRESP, if1.HRDATA,
            if1.HSEL & if1.HREADY & if1.HTRANS[1]);
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? if0.HREADYOUT : if1.HREADYOUT;
    endfunction

    // Drive one address phase plus previous write data.
    task automatic beat(input int d,
                        input logic [1:0] tr,
                        input logic wr,
                        input logic [31:0] a,
                        input logic [2:0] sz,
                        input logic [31:0] wd,
                        input exp_t e,
                        input bit push);
        int n;
        sel      = 2'b00;
        sel[d]   = 1'b1;
        htrans   = tr;
        hwrite   = wr;
        haddr    = a;
        hsize    = sz;
        hwdata   = nxt_wd;
        nxt_wd   = wd;
        if (push && tr[1]) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy(d)) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d", d);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [1:0] tr,
                      input logic [31:0] a,
                      input logic [2:0] sz,
                      input logic [31:0] wd,
                      input bit err);
        exp_t e;
        e.rd    = 1'b0;
        e.neq   = 1'b0;
        e.data  = '0;
        e.resp  = err;
        e.waits = err ? 1 : ((d == 1) ? 3 : 0);
        beat(d, tr, 1'b1, a, sz, wd, e, 1'b1);
    endtask

    task automatic rd(input int d, input logic [1:0] tr,
                      input logic [31:0] a,
                      input logic [31:0] x,
                      input bit neq);
        exp_t e;
        e.rd    = 1'b1;
        e.neq   = neq;
        e.data  = x;
        e.resp  = 1'b0;
        e.waits = (d == 1) ? 3 : 0;
        beat(d, tr, 1'b0, a, SZ_WORD, '0, e, 1'b1);
    endtask

    task automatic idle(input int d);
        exp_t e;
        e.rd    = 1'b0;
        e.neq   = 1'b0;
        e.data  = '0;
        e.resp  = 1'b0;
        e.waits = 0;
        beat(d, 2'b00, 1'b0, '0, SZ_WORD, '0, e, 1'b0);
    endtask

    task automatic chk_reset();
        chk("rst_hreadyout0", 32'(if0.HREADYOUT), 32'd1);
        chk("rst_hresp0",     32'(if0.HRESP),     32'd0);
        chk("rst_hrdata0",    if0.HRDATA,         32'd0);
        chk("rst_hreadyout1", 32'(if1.HREADYOUT), 32'd1);
    endtask

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    initial begin
        exp_t ex;
        repeat (3) begin
            @(negedge clk);
            chk_reset();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a write data phase
        wr(0, NS, 32'h10, SZ_WORD, 32'h1111_1111, 1'b0);
        idle(0);
        ex.rd = 1'b0; ex.neq = 1'b0; ex.data = '0;
        ex.resp = 1'b0; ex.waits = 0;
        beat(0, NS, 1'b1, 32'h10, SZ_WORD,
             32'hDEAD_BEEF, ex, 1'b0);
        hwdata = 32'hDEAD_BEEF;
        sel    = 2'b00;
        htrans = 2'b00;
        rst_n  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(0, NS, 32'h10, 32'h1111_1111, 1'b0);
        idle(0);

        // zero-wait write then back-to-back read
        wr(0, NS, 32'h20, SZ_WORD, 32'hA5A5_1234, 1'b0);
        rd(0, NS, 32'h20, 32'hA5A5_1234, 1'b0);
        idle(0);

        // byte and halfword lanes
        wr(0, NS, 32'h30, SZ_WORD, 32'h0000_0000, 1'b0);
        wr(0, SQ, 32'h31, SZ_BYTE, 32'h0000_7700, 1'b0);
        rd(0, SQ, 32'h30, 32'h0000_7700, 1'b0);
        wr(0, NS, 32'h32, SZ_HALF, 32'hBEEF_0000, 1'b0);
        rd(0, SQ, 32'h30, 32'hBEEF_7700, 1'b0);
        idle(0);

        // error responses leave memory untouched
        wr(0, NS, 32'h00, SZ_WORD, 32'hCAFE_F00D, 1'b0);
        wr(0, NS, 32'h08, SZ_WORD, 32'h0BAD_C0DE, 1'b0);
        wr(0, NS, 32'h02, SZ_WORD, 32'hFFFF_FFFF, 1'b1);
        wr(0, NS, 32'h400, SZ_WORD, 32'hFFFF_FFFF, 1'b1);
        wr(0, NS, 32'h08, SZ_DWORD, 32'hFFFF_FFFF, 1'b1);
        rd(0, NS, 32'h00, 32'hCAFE_F00D, 1'b0);
        rd(0, NS, 32'h08, 32'h0BAD_C0DE, 1'b0);
        idle(0);

        // read-only region boundary
        wr(0, NS, 32'h2FC, SZ_WORD, 32'h2222_2222, 1'b0);
        rd(0, NS, 32'h2FC, 32'h2222_2222, 1'b0);
`ifdef AHB_SLV_RO_REGION_EN
        wr(0, NS, 32'h300, SZ_WORD, 32'h0000_0001, 1'b1);
        rd(0, NS, 32'h300, 32'h0000_0001, 1'b1);
`else
        wr(0, NS, 32'h300, SZ_WORD, 32'h0000_0001, 1'b0);
        rd(0, NS, 32'h300, 32'h0000_0001, 1'b0);
`endif
        idle(0);

        // three wait states on dut1
        wr(1, NS, 32'h40, SZ_WORD, 32'h600D_F00D, 1'b0);
        rd(1, NS, 32'h40, 32'h600D_F00D, 1'b0);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("idle_nowait", 32'(if1.HREADYOUT), 32'd1);
        @(posedge clk);
        #1;
        wr(1, NS, 32'h41, SZ_HALF, 32'hFFFF_FFFF, 1'b1);
        rd(1, NS, 32'h40, 32'h600D_F00D, 1'b0);
        idle(1);

        sel    = 2'b00;
        htrans = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained",
            32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Parametrised AHB-Lite slave fronting an on-chip byte-addressable SRAM.
- Next-generation DUT for the AHB slave verification environment: configurable data width, depth and wait states.
- Adds byte/halfword/word sizing, SEQ bursts, programmable wait states and two-cycle ERROR responses, none of which the prior fixed slave had.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
- DEPTH, 256, memory depth in DATA_W words; power of two.
- WAIT_STATES, 0, wait cycles inserted per valid transfer; range 0..15.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word, 3=dword.
- HWDATA  in  DATA_W  write data; sampled in the data phase.
- HREADY  in  1  bus ready (all slaves).
- HRDATA  out  DATA_W  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async assert, sync release): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, all captured address-phase registers cleared. Memory contents are not reset. Reset mid-transfer abandons the transfer; a pending write is not committed.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] at a rising HCLK. The slave then captures addr, write, size and the error flag.
- IDLE/BUSY, or HSEL=0: zero-wait OKAY, no memory access.
- Error if any of the following:
  - address is not aligned to HSIZE;
  - (8<<HSIZE) > DATA_W;
  - HADDR >= DEPTH*DATA_W/8.
- FSM states:
  - IDLE → ERR1 on an accepted error transfer.
  - IDLE → WAIT on a valid transfer with WAIT_STATES>0.
  - IDLE → DATA on a valid transfer with WAIT_STATES=0.
  - WAIT → DATA when the counter reaches 1.
  - DATA → IDLE/WAIT/ERR1 according to the next accepted address phase, or IDLE if none.
  - ERR1 → ERR2 unconditionally. ERR2 → IDLE/WAIT/ERR1 as DATA.
- Outputs per state:
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES at acceptance and decrements each cycle.
  - DATA: HREADYOUT=1, HRESP=0. Writes commit at the end of DATA using byte enables from size/addr low bits (little-endian lanes). Reads drive HRDATA with the full addressed word; unselected lanes are don't-care but the RTL drives the true memory content.
  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. An errored write is never committed.
- Latency: a read completes after WAIT_STATES+1 cycles measured from address acceptance.
- Pipelining: the next address phase overlaps the DATA/ERR2 cycle. Write-then-read to the same address returns the new data with no stall.
- SEQ beats are treated exactly as NONSEQ. The address is taken from HADDR; there is no internal incrementing, so wrap bursts are master-controlled.
- HREADY=0 from another slave holds acceptance off; the internal state is unchanged.

Optional Feature:
- Macro: AHB_SLV_RO_REGION_EN.
- Defined: the top quarter of memory (word index >= 3*DEPTH/4) is read-only. Writes to it take the ERR1/ERR2 response and the memory is unchanged. Reads are normal.
- Undefined: the whole memory is read/write, and no extra logic is generated.

Decomposition:
- Package ahb_slv_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hsize encodings;
  - hresp constants OKAY/ERROR;
  - FSM state enum slv_state_e {IDLE, WAIT, DATA, ERR1, ERR2};
  - a function computing byte enables from size and low address bits.
- One sub-module, ahb_sram_bank: DEPTH×DATA_W array, byte-enable write port, combinational read port.

Test Plan (DATA_W=32, DEPTH=256):
- Reset: HRESETn low for 3 cycles mid-write of 0xDEADBEEF to 0x10 → HREADYOUT=1, HRESP=0, HRDATA=0. A subsequent read of 0x10 does not return 0xDEADBEEF.
- WAIT_STATES=0: write word 0xA5A5_1234 @0x20, then back-to-back read @0x20 → HRDATA=0xA5A51234 in the next data phase, HREADYOUT never low.
- WAIT_STATES=3: NONSEQ read → HREADYOUT low for exactly 3 cycles, then high with data; IDLE transfers see zero wait.
- Byte lanes: write byte 0x77 @0x31 over prior word 0x00000000 @0x30 → read @0x30 returns 0x00007700. Halfword 0xBEEF @0x32 → 0xBEEF7700.
- Errors: unaligned word @0x02, word @0x400 (out of range), and HSIZE=3 each → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. Memory is unchanged.
- With AHB_SLV_RO_REGION_EN: write 0x1 @0x300 → two-cycle ERROR, and read @0x300 returns the prior value. Without the macro: OKAY and read returns 0x1.
